// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_pkg
// Purpose  : Shared definitions for the iterative divider. It holds the state
//            encodings, the operand/result/counter widths and a small
//            conditional-negate helper. These are the same values the legacy
//            mycpu_head.h header carried.
// Revision : 1.0 - initial release
// ============================================================================
package div_iter_pkg;

    localparam int C_DATA_W   = 32;   // operand width
    localparam int C_RESULT_W = 64;   // {quotient, remainder}
    localparam int C_CNT_W    = 6;    // iteration counter width

    // The BUSY cycle with this counter value performs the final (32nd) step.
    localparam logic [C_CNT_W-1:0] C_LAST_STEP = 6'd31;

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_BUSY = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    // Two's-complement negate when neg is set, pass through otherwise.
    function automatic logic [C_DATA_W-1:0] f_neg_if(
        input logic [C_DATA_W-1:0] x,
        input logic                neg
    );
        return neg ? (~x + 1'b1) : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring shift-subtract step.
// Ports    : part_rem  in  33  shifted partial remainder {rem, next dividend bit}
//            divisor   in  32  divisor magnitude
//            rem_next  out 32  partial remainder after this step
//            q_bit     out 1   quotient bit produced by this step
// Revision : 1.0 - initial release
// ============================================================================
module div_step
    import div_iter_pkg::*;
(
    input  logic [C_DATA_W:0]   part_rem,
    input  logic [C_DATA_W-1:0] divisor,
    output logic [C_DATA_W-1:0] rem_next,
    output logic                q_bit
);

    logic [C_DATA_W:0] w_diff;

    assign w_diff = part_rem - {1'b0, divisor};

    // No borrow means the divisor fits: keep the difference. The restored
    // value always fits 32 bits because part_rem < 2 * divisor here.
    assign q_bit    = ~w_diff[C_DATA_W];
    assign rem_next = q_bit ? w_diff[C_DATA_W-1:0] : part_rem[C_DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Purpose  : 32-bit iterative restoring divider with AXI-Stream style operand
//            and result channels. It performs one quotient bit per cycle, so
//            a result appears 33 cycles after acceptance. Both operands are
//            accepted together as a pair. There is no output back-pressure.
// Params   : SIGNED  1 = two's-complement operands, 0 = unsigned
// Macro    : DIV_ZERO_FAST_EN - when defined, a zero divisor skips the
//            iterations and the result is presented in the next cycle.
// Ports    : clk                     in   1  rising-edge clock
//            resetn                  in   1  asynchronous active-low reset
//            s_axis_dividend_tvalid  in   1  dividend offered
//            s_axis_dividend_tdata   in  32  dividend
//            s_axis_dividend_tready  out  1  dividend accepted this cycle
//            s_axis_divisor_tvalid   in   1  divisor offered
//            s_axis_divisor_tdata    in  32  divisor
//            s_axis_divisor_tready   out  1  divisor accepted this cycle
//            m_axis_dout_tvalid      out  1  one-cycle result strobe
//            m_axis_dout_tdata       out 64  {quotient, remainder}
// Revision : 1.0 - initial release
// ============================================================================
module div_iter
    import div_iter_pkg::*;
#(
    parameter int SIGNED = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_axis_dividend_tvalid,
    input  logic [C_DATA_W-1:0]   s_axis_dividend_tdata,
    output logic                  s_axis_dividend_tready,
    input  logic                  s_axis_divisor_tvalid,
    input  logic [C_DATA_W-1:0]   s_axis_divisor_tdata,
    output logic                  s_axis_divisor_tready,
    output logic                  m_axis_dout_tvalid,
    output logic [C_RESULT_W-1:0] m_axis_dout_tdata
);

    logic [1:0]            r_state;
    logic [C_CNT_W-1:0]    r_cnt;
    logic [C_DATA_W-1:0]   r_rem;     // partial remainder
    logic [C_DATA_W-1:0]   r_quo;     // dividend bits shift out, quotient bits shift in
    logic [C_DATA_W-1:0]   r_dvsr;    // divisor magnitude
    logic                  r_q_neg;
    logic                  r_r_neg;
    logic                  r_dz;      // divisor was zero
    logic [C_RESULT_W-1:0] r_dout;

    logic                  w_accept;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [C_DATA_W-1:0]   w_a_mag;
    logic [C_DATA_W-1:0]   w_b_mag;
    logic                  w_div_zero;
    logic [C_DATA_W-1:0]   w_rem_next;
    logic                  w_q_bit;
    logic [C_DATA_W-1:0]   w_quo_fin;
    logic [C_DATA_W-1:0]   w_quo_res;
    logic [C_DATA_W-1:0]   w_rem_res;

    // Ready is gated by resetn so it drops the moment reset is asserted,
    // not just at the next edge.
    assign w_accept = resetn && (r_state == C_IDLE) &&
                      s_axis_dividend_tvalid && s_axis_divisor_tvalid;

    assign s_axis_dividend_tready = w_accept;
    assign s_axis_divisor_tready  = w_accept;

    assign w_a_neg    = (SIGNED != 0) && s_axis_dividend_tdata[C_DATA_W-1];
    assign w_b_neg    = (SIGNED != 0) && s_axis_divisor_tdata[C_DATA_W-1];
    assign w_a_mag    = f_neg_if(s_axis_dividend_tdata, w_a_neg);
    assign w_b_mag    = f_neg_if(s_axis_divisor_tdata, w_b_neg);
    assign w_div_zero = (s_axis_divisor_tdata == '0);

    div_step u_step (
        .part_rem (({r_rem, r_quo[C_DATA_W-1]})),
        .divisor  (r_dvsr),
        .rem_next (w_rem_next),
        .q_bit    (w_q_bit)
    );

    // Result of the final step is sign-corrected on its way into the output
    // register so DONE follows the 32nd step directly. With a zero divisor
    // every step yields a 1 quotient bit and the remainder rebuilds the
    // dividend magnitude; restoring its sign returns the dividend unchanged.
    assign w_quo_fin = {r_quo[C_DATA_W-2:0], w_q_bit};
    assign w_quo_res = r_dz ? {C_DATA_W{1'b1}} : f_neg_if(w_quo_fin, r_q_neg);
    assign w_rem_res = f_neg_if(w_rem_next, r_r_neg);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= C_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_dz    <= 1'b0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_accept) begin
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_dvsr  <= w_b_mag;
                        r_q_neg <= w_a_neg ^ w_b_neg;
                        r_r_neg <= w_a_neg;
                        r_dz    <= w_div_zero;
                        r_cnt   <= '0;
`ifdef DIV_ZERO_FAST_EN
                        if (w_div_zero) begin
                            r_dout  <= {{C_DATA_W{1'b1}}, s_axis_dividend_tdata};
                            r_state <= C_DONE;
                        end else begin
                            r_state <= C_BUSY;
                        end
`else
                        r_state <= C_BUSY;
`endif
                    end
                end
                C_BUSY: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_fin;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST_STEP) begin
                        r_dout  <= {w_quo_res, w_rem_res};
                        r_state <= C_DONE;
                    end
                end
                C_DONE: begin
                    r_state <= C_IDLE;
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    assign m_axis_dout_tvalid = (r_state == C_DONE);
    assign m_axis_dout_tdata  = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Purpose  : Self-checking bench for div_iter. An unsigned and a signed
//            instance share one stimulus stream. Expected results and due
//            cycles are queued on acceptance and compared when each instance
//            raises its result strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif
    localparam int NLAT = 33;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        a_valid = 1'b0;
    logic        b_valid = 1'b0;
    logic [31:0] a_data  = '0;
    logic [31:0] b_data  = '0;

    logic        u_a_rdy, u_b_rdy, u_vld;
    logic [63:0] u_dout;
    logic        s_a_rdy, s_b_rdy, s_vld;
    logic [63:0] s_dout;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t sb_u[$];
    exp_t sb_s[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        u_seen   = 1'b0;
    logic        s_seen   = 1'b0;
    logic [63:0] u_last   = '0;
    logic [63:0] s_last   = '0;

    always #5 clk = ~clk;

    div_iter #(.SIGNED(0)) u_dut_u (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tvalid (a_valid),
        .s_axis_dividend_tdata  (a_data),
        .s_axis_dividend_tready (u_a_rdy),
        .s_axis_divisor_tvalid  (b_valid),
        .s_axis_divisor_tdata   (b_data),
        .s_axis_divisor_tready  (u_b_rdy),
        .m_axis_dout_tvalid     (u_vld),
        .m_axis_dout_tdata      (u_dout)
    );

    div_iter #(.SIGNED(1)) u_dut_s (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tvalid (a_valid),
        .s_axis_dividend_tdata  (a_data),
        .s_axis_dividend_tready (s_a_rdy),
        .s_axis_divisor_tvalid  (b_valid),
        .s_axis_divisor_tdata   (b_data),
        .s_axis_divisor_tready  (s_b_rdy),
        .m_axis_dout_tvalid     (s_vld),
        .m_axis_dout_tdata      (s_dout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: SystemVerilog integer division truncates toward zero and the
    // remainder takes the dividend's sign, evaluated in 64 bits.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sd, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!sgn) return {a / b, a % b};
        sa = longint'($signed(a));
        sd = longint'($signed(b));
        q  = sa / sd;
        r  = sa % sd;
        return {q[31:0], r[31:0]};
    endfunction

    function automatic int lat_of(input logic [31:0] b);
        return (b == 32'd0) ? ZLAT : NLAT;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge resetn) begin
        sb_u.delete();
        sb_s.delete();
        u_last = '0;
        s_last = '0;
    end

    // Monitor: cycles are indexed by the number of rising edges seen so far;
    // latency is the strobe cycle minus the cycle in which ready was high.
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (u_a_rdy || u_b_rdy) begin
                check_eq("u_rdy_pair", {62'd0, u_a_rdy, u_b_rdy}, 64'd3);
                sb_u.push_back('{model(a_data, b_data, 1'b0), cyc + lat_of(b_data)});
            end
            if (s_a_rdy || s_b_rdy) begin
                check_eq("s_rdy_pair", {62'd0, s_a_rdy, s_b_rdy}, 64'd3);
                sb_s.push_back('{model(a_data, b_data, 1'b1), cyc + lat_of(b_data)});
            end
            if (u_vld) begin
                if (sb_u.size() == 0) begin
                    check_eq("u_unexpected_tvalid", 64'd1, 64'd0);
                end else begin
                    e = sb_u.pop_front();
                    check_eq("u_data", u_dout, e.data);
                    check_eq("u_latency", 64'(cyc), 64'(e.due));
                end
                u_last = u_dout;
                u_seen = 1'b1;
            end else if (u_seen) begin
                check_eq("u_hold", u_dout, u_last);
            end
            if (s_vld) begin
                if (sb_s.size() == 0) begin
                    check_eq("s_unexpected_tvalid", 64'd1, 64'd0);
                end else begin
                    e = sb_s.pop_front();
                    check_eq("s_data", s_dout, e.data);
                    check_eq("s_latency", 64'(cyc), 64'(e.due));
                end
                s_last = s_dout;
                s_seen = 1'b1;
            end else if (s_seen) begin
                check_eq("s_hold", s_dout, s_last);
            end
        end
    end

    // Offer one operand pair; both instances are idle so it must be taken
    // in the first cycle.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        a_data  = a;
        b_data  = b;
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(negedge clk);
        check_eq("ready_on_offer", {60'd0, u_a_rdy, u_b_rdy, s_a_rdy, s_b_rdy}, 64'hF);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            #1;
            if (sb_u.size() == 0 && sb_s.size() == 0) done = 1'b1;
        end
        check_eq("result_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {u_vld, u_a_rdy, u_b_rdy, s_vld, s_a_rdy, s_b_rdy, 58'd0}, 64'd0);
        check_eq({tag, "_data"}, u_dout | s_dout, 64'd0);
    endtask

    initial begin
        int pulses;
        logic [31:0] ra, rb;

        // Reset state, with both valids offered while reset is held.
        a_valid = 1'b1;
        b_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #3 resetn = 1'b1;

        // Directed vectors
        do_div(32'd100, 32'd7);                wait_idle();
        do_div(32'hFFFF_FFF9, 32'd2);          wait_idle();
        do_div(32'h8000_0000, 32'hFFFF_FFFF);  wait_idle();
        do_div(32'h1234_5678, 32'd0);          wait_idle();
        do_div(32'hFFFF_FFF9, 32'd0);          wait_idle();
        do_div(32'h8000_0000, 32'd0);          wait_idle();
        do_div(32'd5, 32'd9);                  wait_idle();
        do_div(32'd7, 32'hFFFF_FFF9);          wait_idle();
        do_div(32'hFFFF_FFFF, 32'd1);          wait_idle();
        do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_idle();

        // Random vectors with spread divisor magnitudes
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            do_div(ra, rb);
            wait_idle();
        end

        // Lone dividend valid: nothing is taken until the divisor shows up.
        @(posedge clk);
        #1;
        a_data  = 32'd50;
        b_data  = 32'd5;
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("lone_valid_ready", {60'd0, u_a_rdy, u_b_rdy, s_a_rdy, s_b_rdy}, 64'd0);
            @(posedge clk);
            #1;
        end
        b_valid = 1'b1;
        @(negedge clk);
        check_eq("pair_ready", {60'd0, u_a_rdy, u_b_rdy, s_a_rdy, s_b_rdy}, 64'hF);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        wait_idle();

        // Operands offered while busy are ignored.
        do_div(32'd1000, 32'd33);
        #1;
        a_data  = 32'd77;
        b_data  = 32'd7;
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("busy_ready", {60'd0, u_a_rdy, u_b_rdy, s_a_rdy, s_b_rdy}, 64'd0);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a division.
        do_div(32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #3;
        resetn  = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        check_all_zero("mid_reset_held");
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1 resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (u_vld || s_vld) pulses++;
        end
        check_eq("no_pulse_after_reset", 64'(pulses), 64'd0);

        do_div(32'd9, 32'd3);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter SIGNED, default 1; 1 = two's-complement operands, 0 = unsigned.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port resetn  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port s_axis_dividend_tvalid  input  1  dividend offered.
REQ-005 SHALL have port s_axis_dividend_tdata  input  32  dividend.
REQ-006 SHALL have port s_axis_dividend_tready  output  1  dividend accepted this cycle.
REQ-007 SHALL have port s_axis_divisor_tvalid  input  1  divisor offered.
REQ-008 SHALL have port s_axis_divisor_tdata  input  32  divisor.
REQ-009 SHALL have port s_axis_divisor_tready  output  1  divisor accepted this cycle.
REQ-010 SHALL have port m_axis_dout_tvalid  output  1  result valid, single-cycle pulse.
REQ-011 SHALL have port m_axis_dout_tdata  output  64  {quotient[63:32], remainder[31:0]}.

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE.
REQ-013 SHALL drive both treadys high only in IDLE with both tvalids high, so operands are always accepted as a pair.
REQ-014 SHALL ignore a lone tvalid on one channel: no ready, no state change.
REQ-015 SHALL, on acceptance, latch operand magnitudes and result signs, clear the 6-bit iteration counter, and go IDLE->BUSY.
REQ-016 SHALL perform one restoring shift-subtract step per BUSY cycle, 32 steps total, then go BUSY->DONE.
REQ-017 SHALL assert m_axis_dout_tvalid only in DONE, exactly one cycle, then go DONE->IDLE unconditionally; there is no output back-pressure.
REQ-018 SHALL give latency of exactly 33 cycles from the acceptance edge to the cycle tvalid is high; back-to-back throughput is one division per 34 cycles.
REQ-019 SHALL hold m_axis_dout_tdata stable from DONE until the next DONE.
REQ-020 SHALL, when SIGNED=1, truncate the quotient toward zero, give the remainder the dividend's sign, and return 0x80000000/0x00000000 for 0x80000000 / 0xFFFFFFFF.
REQ-021 SHALL, for divisor 0 in either mode, return quotient 0xFFFFFFFF and remainder equal to the dividend.
REQ-022 SHALL not accept new operands in BUSY or DONE; tvalids seen there are ignored.

Reset
REQ-023 SHALL, on resetn low at any time, including mid-division, immediately force IDLE, counter 0, m_axis_dout_tvalid 0, m_axis_dout_tdata 0, and both treadys 0.
REQ-024 SHALL discard any division in progress at reset; no tvalid pulse follows reset release.

Configuration
REQ-025 SHALL, with DIV_ZERO_FAST_EN defined, take divisor-0 operands IDLE->DONE directly, giving a 1-cycle latency with the REQ-021 result.
REQ-026 SHALL, without DIV_ZERO_FAST_EN, run divisor 0 through all 32 BUSY cycles with the same REQ-021 result.

Structure
REQ-027 SHALL take state encodings and width defines (operand width 32, result width 64, counter width 6) from the shared mycpu_head.h header.
REQ-028 SHALL place one combinational step in sub-module div_step: partial remainder and divisor in, next remainder and quotient bit out.

Verification
REQ-029 SHALL cover, with SIGNED=0: 100 / 7 -> tvalid 33 cycles after acceptance, tdata = {0x0000000E, 0x00000002}.
REQ-030 SHALL cover, with SIGNED=1: -7 (0xFFFFFFF9) / 2 -> {0xFFFFFFFD, 0xFFFFFFFF}.
REQ-031 SHALL cover, with SIGNED=1: 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0x00000000}.
REQ-032 SHALL cover divisor 0, dividend 0x12345678 -> {0xFFFFFFFF, 0x12345678}; latency 1 cycle with DIV_ZERO_FAST_EN, 33 cycles without.
REQ-033 SHALL cover dividend tvalid alone for 5 cycles -> treadys stay 0; then divisor tvalid -> accepted that cycle.
REQ-034 SHALL cover resetn low at BUSY cycle 10 -> tvalid never pulses; a fresh 9 / 3 after release -> {3, 0} at 33 cycles.
